// File: rtl/mem_responder_pkg.sv
// Shared definitions for the mem_responder memory target: per-channel
// state encodings, the word returned for illegal fetches and the width
// of the per-channel latency counter.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        MR_IDLE = 2'd0,
        MR_WAIT = 2'd1,
        MR_ACK  = 2'd2
    } mr_state_e;

    // Returned to the fetch channel for an out-of-range address; decodes
    // as an illegal instruction so the core halts.
    localparam logic [31:0] MR_ILLEGAL_WORD = 32'hFFFF_FFFF;

    // LATENCY is limited to 1..15, so four bits hold LATENCY-1.
    localparam int MR_CNT_W = 4;

    // Counter preload for a given access latency.
    function automatic logic [MR_CNT_W-1:0] mr_cnt_load(input int latency);
        return MR_CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/mem_channel_fsm.sv
// One request channel of mem_responder: latches the request at acceptance,
// counts down the access latency and asks the arbiter for the array port.
// "want" is raised on the cycle whose closing edge should enter ACK; the
// access happens on that edge only when "grant" is also high.
import mem_responder_pkg::*;

module mem_channel_fsm #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        rw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        grant,
    output logic        want,
    output logic        access,
    output logic        ack,
    output logic        acc_rw,
    output logic [31:0] acc_addr,
    output logic [31:0] acc_wdata
);

    localparam logic [MR_CNT_W-1:0] CNT_LOAD = mr_cnt_load(LATENCY);

    mr_state_e             state_q, state_d;
    logic [MR_CNT_W-1:0]   cnt_q, cnt_d;
    logic                  rw_q, rw_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    // Port request: a single-cycle latency wants the port straight from IDLE,
    // otherwise WAIT asks once the counter is on its last step (or has
    // already expired because an earlier request lost arbitration).
    // Gated by reset so nothing reaches the array while reset is held.
    assign want = reset_n &&
                  (((state_q == MR_IDLE) && req && (CNT_LOAD == '0)) ||
                   ((state_q == MR_WAIT) && (cnt_q <= MR_CNT_W'(1))));

    assign access = want && grant;
    assign ack    = (state_q == MR_ACK);

    // In IDLE the access (LATENCY=1 case) uses the live request fields,
    // afterwards the latched copy so later input changes are ignored.
    assign acc_rw    = (state_q == MR_IDLE) ? rw    : rw_q;
    assign acc_addr  = (state_q == MR_IDLE) ? addr  : addr_q;
    assign acc_wdata = (state_q == MR_IDLE) ? wdata : wdata_q;

    // Next-state: accept, count down, enter ACK when granted, then return.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            MR_IDLE: begin
                if (req) begin
                    rw_d    = rw;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = access ? MR_ACK : MR_WAIT;
                end
            end
            MR_WAIT: begin
                if (cnt_q <= MR_CNT_W'(1)) begin
                    cnt_d = '0;
                    if (access) begin
                        state_d = MR_ACK;
                    end
                end else begin
                    cnt_d = cnt_q - MR_CNT_W'(1);
                end
            end
            MR_ACK: begin
                state_d = MR_IDLE;
            end
            default: begin
                state_d = MR_IDLE;
            end
        endcase
    end

    // State, counter and request latch registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MR_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory target serving an instruction-fetch
// channel (read-only) and a data channel (read/write) from one single-port
// array. Data wins a same-edge conflict; the fetch retries next edge.
// Optional build macro MEM_RESPONDER_ERR_EN enables the address range check
// (data_err, read-as-zero, dropped writes, illegal-word fetches); without
// it addresses wrap modulo the array depth and data_err is 0.
import mem_responder_pkg::*;

module mem_responder #(
    parameter int          ADDR_BITS = 10,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        insn_req,
    input  logic [31:0] insn_addr,
    output logic [31:0] insn_data,
    output logic        insn_ack,
    input  logic        data_req,
    input  logic        data_rw,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ack,
    output logic        data_err
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [31:0] mem_array [0:DEPTH-1];

    logic        insn_want, insn_grant, insn_access;
    logic        insn_acc_rw;
    logic [31:0] insn_acc_addr, insn_acc_wdata;
    logic        data_want, data_grant, data_access;
    logic        data_acc_rw;
    logic [31:0] data_acc_addr, data_acc_wdata;

    logic                 insn_in_range, data_in_range;
    logic [ADDR_BITS-1:0] insn_idx, data_idx, rd_idx;
    logic [31:0]          rd_word;
    logic                 unused_bits;

    logic [31:0] insn_data_q, insn_data_d;
    logic [31:0] data_rdata_q, data_rdata_d;

    mem_channel_fsm #(.LATENCY(LATENCY)) u_insn_ch (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (insn_req),
        .rw        (1'b0),
        .addr      (insn_addr),
        .wdata     (32'h0),
        .grant     (insn_grant),
        .want      (insn_want),
        .access    (insn_access),
        .ack       (insn_ack),
        .acc_rw    (insn_acc_rw),
        .acc_addr  (insn_acc_addr),
        .acc_wdata (insn_acc_wdata)
    );

    mem_channel_fsm #(.LATENCY(LATENCY)) u_data_ch (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (data_req),
        .rw        (data_rw),
        .addr      (data_addr),
        .wdata     (data_wdata),
        .grant     (data_grant),
        .want      (data_want),
        .access    (data_access),
        .ack       (data_ack),
        .acc_rw    (data_acc_rw),
        .acc_addr  (data_acc_addr),
        .acc_wdata (data_acc_wdata)
    );

    // Fixed priority for the single array port: data first. A channel never
    // wants the port in the cycle right after its access (it sits in ACK),
    // so the fetch channel always gets the following slot.
    assign data_grant = data_want;
    assign insn_grant = !data_want;

    assign insn_idx = insn_acc_addr[ADDR_BITS-1:0];
    assign data_idx = data_acc_addr[ADDR_BITS-1:0];

`ifdef MEM_RESPONDER_ERR_EN
    assign insn_in_range = (insn_acc_addr[31:ADDR_BITS] == BASE[31:ADDR_BITS]);
    assign data_in_range = (data_acc_addr[31:ADDR_BITS] == BASE[31:ADDR_BITS]);
    assign unused_bits   = ^{insn_acc_rw, insn_acc_wdata};
`else
    assign insn_in_range = 1'b1;
    assign data_in_range = 1'b1;
    assign unused_bits   = ^{insn_acc_rw, insn_acc_wdata,
                             insn_acc_addr[31:ADDR_BITS],
                             data_acc_addr[31:ADDR_BITS]};
`endif

    // One shared read address; at most one channel accesses per edge.
    assign rd_idx  = data_access ? data_idx : insn_idx;
    assign rd_word = mem_array[rd_idx];

    // Array write on the edge the data channel enters ACK. Not reset.
    always_ff @(posedge clk) begin
        if (data_access && data_acc_rw && data_in_range) begin
            mem_array[data_idx] <= data_acc_wdata;
        end
    end

    // Read results captured on the access edge, held otherwise. Because the
    // fetch is deferred behind a conflicting write, it sees the new word.
    always_comb begin
        insn_data_d  = insn_data_q;
        data_rdata_d = data_rdata_q;
        if (insn_access) begin
            insn_data_d = insn_in_range ? rd_word : MR_ILLEGAL_WORD;
        end
        if (data_access && !data_acc_rw) begin
            data_rdata_d = data_in_range ? rd_word : 32'h0;
        end
    end

    // Output data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            insn_data_q  <= '0;
            data_rdata_q <= '0;
        end else begin
            insn_data_q  <= insn_data_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign insn_data  = insn_data_q;
    assign data_rdata = data_rdata_q;

`ifdef MEM_RESPONDER_ERR_EN
    logic data_err_q, data_err_d;

    // Error flag follows each data access and holds between acks.
    always_comb begin
        data_err_d = data_err_q;
        if (data_access) begin
            data_err_d = !data_in_range;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_err_q <= 1'b0;
        end else begin
            data_err_q <= data_err_d;
        end
    end

    assign data_err = data_err_q;
`else
    assign data_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (default parameters,
// LATENCY=2). Range checks follow the MEM_RESPONDER_ERR_EN build macro.
module tb_mem_responder;

    localparam int LAT = 2;

    logic        clk;
    logic        reset_n;
    logic        insn_req;
    logic [31:0] insn_addr;
    logic [31:0] insn_data;
    logic        insn_ack;
    logic        data_req;
    logic        data_rw;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ack;
    logic        data_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    mem_responder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .insn_req   (insn_req),
        .insn_addr  (insn_addr),
        .insn_data  (insn_data),
        .insn_ack   (insn_ack),
        .data_req   (data_req),
        .data_rw    (data_rw),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_ack   (data_ack),
        .data_err   (data_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Data transaction; inputs and req are scrambled/dropped right after
    // acceptance so only the latched request can complete it.
    task automatic data_txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int lat);
        int  e0;
        bit  got;
        rdata = '0;
        err   = 1'b0;
        lat   = -1;
        got   = 1'b0;
        @(negedge clk);
        data_req   = 1'b1;
        data_rw    = rw;
        data_addr  = addr;
        data_wdata = wdata;
        @(posedge clk);
        #1;
        e0         = cyc;
        data_req   = 1'b0;
        data_addr  = $urandom;
        data_wdata = $urandom;
        data_rw    = 1'($urandom_range(0, 1));
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (data_ack) begin
                got   = 1'b1;
                lat   = cyc - e0 + 1;
                rdata = data_rdata;
                err   = data_err;
            end
        end
        $display("data  rw=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 rw, addr, wdata, rdata, err, lat);
    endtask

    // Fetch transaction with the same post-acceptance scrambling.
    task automatic insn_txn(input logic [31:0] addr, output logic [31:0] rdata, output int lat);
        int e0;
        bit got;
        rdata = '0;
        lat   = -1;
        got   = 1'b0;
        @(negedge clk);
        insn_req  = 1'b1;
        insn_addr = addr;
        @(posedge clk);
        #1;
        e0        = cyc;
        insn_req  = 1'b0;
        insn_addr = $urandom;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (insn_ack) begin
                got   = 1'b1;
                lat   = cyc - e0 + 1;
                rdata = insn_data;
            end
        end
        $display("insn  addr=%h -> data=%h lat=%0d", addr, rdata, lat);
    endtask

    initial begin
        logic [31:0] rd, ird;
        logic        err;
        int          lat, ilat, acks, e0, t1, t2;

        insn_req   = 1'b0;
        insn_addr  = '0;
        data_req   = 1'b0;
        data_rw    = 1'b0;
        data_addr  = '0;
        data_wdata = '0;
        reset_n    = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_insn_ack",   32'(insn_ack),   32'h0);
        check_eq("rst_data_ack",   32'(data_ack),   32'h0);
        check_eq("rst_data_err",   32'(data_err),   32'h0);
        check_eq("rst_insn_data",  insn_data,       32'h0);
        check_eq("rst_data_rdata", data_rdata,      32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Preload through the data channel.
        data_txn(1'b1, 32'h000, 32'h1111_0000, rd, err, lat);
        data_txn(1'b1, 32'h001, 32'h2222_0001, rd, err, lat);
        data_txn(1'b1, 32'h020, 32'hA5A5_0020, rd, err, lat);
        data_txn(1'b1, 32'h030, 32'h5A5A_0030, rd, err, lat);
        data_txn(1'b1, 32'h040, 32'hCAFE_F00D, rd, err, lat);

        // Write then fetch.
        data_txn(1'b1, 32'h010, 32'hDEAD_BEEF, rd, err, lat);
        check_eq("wr_lat", 32'(lat), 32'(LAT));
        check_eq("wr_err", 32'(err), 32'h0);
        insn_txn(32'h010, ird, ilat);
        check_eq("fetch_data", ird, 32'hDEAD_BEEF);
        check_eq("fetch_lat", 32'(ilat), 32'(LAT));
        data_txn(1'b0, 32'h010, 32'h0, rd, err, lat);
        check_eq("rd_back", rd, 32'hDEAD_BEEF);

        // Same-edge conflict: data first, fetch one cycle later.
        fork
            insn_txn(32'h020, ird, ilat);
            data_txn(1'b0, 32'h030, 32'h0, rd, err, lat);
        join
        check_eq("cfl_data_lat", 32'(lat), 32'(LAT));
        check_eq("cfl_insn_lat", 32'(ilat), 32'(LAT + 1));
        check_eq("cfl_data_val", rd, 32'h5A5A_0030);
        check_eq("cfl_insn_val", ird, 32'hA5A5_0020);

        // Read-after-write in the conflicting slot.
        fork
            insn_txn(32'h050, ird, ilat);
            data_txn(1'b1, 32'h050, 32'h0BAD_C0DE, rd, err, lat);
        join
        check_eq("raw_insn_val", ird, 32'h0BAD_C0DE);
        check_eq("raw_insn_lat", 32'(ilat), 32'(LAT + 1));

        // Back-to-back fetches with insn_req held high.
        @(negedge clk);
        insn_req  = 1'b1;
        insn_addr = 32'h000;
        @(posedge clk);
        #1;
        e0 = cyc;
        t1 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (insn_ack) begin
                t1 = cyc - e0 + 1;
                break;
            end
        end
        check_eq("b2b_t1", 32'(t1), 32'(LAT));
        check_eq("b2b_d1", insn_data, 32'h1111_0000);
        insn_addr = 32'h001;
        @(negedge clk);
        check_eq("b2b_pulse", 32'(insn_ack), 32'h0);
        t2 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (insn_ack) begin
                t2 = cyc - e0 + 1;
                break;
            end
        end
        insn_req = 1'b0;
        check_eq("b2b_t2", 32'(t2), 32'(2 * LAT + 1));
        check_eq("b2b_d2", insn_data, 32'h2222_0001);
        $display("b2b   acks at +%0d and +%0d", t1, t2);

        // Address range handling.
`ifdef MEM_RESPONDER_ERR_EN
        data_txn(1'b0, 32'h400, 32'h0, rd, err, lat);
        check_eq("oob_rd_val", rd, 32'h0);
        check_eq("oob_rd_err", 32'(err), 32'h1);
        check_eq("oob_rd_lat", 32'(lat), 32'(LAT));
        insn_txn(32'h400, ird, ilat);
        check_eq("oob_fetch", ird, 32'hFFFF_FFFF);
        data_txn(1'b1, 32'h400, 32'h9999_9999, rd, err, lat);
        check_eq("oob_wr_err", 32'(err), 32'h1);
        data_txn(1'b0, 32'h000, 32'h0, rd, err, lat);
        check_eq("oob_wr_drop", rd, 32'h1111_0000);
        check_eq("inr_err", 32'(err), 32'h0);
`else
        data_txn(1'b0, 32'h400, 32'h0, rd, err, lat);
        check_eq("wrap_rd_val", rd, 32'h1111_0000);
        check_eq("wrap_rd_err", 32'(err), 32'h0);
        insn_txn(32'h401, ird, ilat);
        check_eq("wrap_fetch", ird, 32'h2222_0001);
`endif

        // Reset during WAIT aborts a write.
        @(negedge clk);
        data_req   = 1'b1;
        data_rw    = 1'b1;
        data_addr  = 32'h040;
        data_wdata = 32'h1234_5678;
        @(posedge clk);
        #2;
        data_req = 1'b0;
        reset_n  = 1'b0;
        #1;
        check_eq("abort_ack",   32'(data_ack), 32'h0);
        check_eq("abort_idata", insn_data,     32'h0);
        check_eq("abort_rdata", data_rdata,    32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (data_ack) acks++;
        end
        check_eq("abort_no_ack", 32'(acks), 32'h0);
        data_txn(1'b0, 32'h040, 32'h0, rd, err, lat);
        check_eq("abort_old_val", rd, 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
